// File: rtl/noc_flit_sink_axis_if.sv
// Receive-side NoC link (flit + credit) bundled with the AXI-Stream output it feeds.
// The slave modport is the sink's view; master is the view of whoever drives flits and consumes beats.
interface noc_flit_sink_axis_if #(
    parameter int FLIT_WIDTH  = 32,
    parameter int DEST_WIDTH  = 6,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 4
) ();
    logic [FLIT_WIDTH-1:0]  data_in;
    logic [DEST_WIDTH-1:0]  dest_in;
    logic                   is_tail_in;
    logic                   send_in;
    logic                   credit_out;
    logic                   axis_out_tvalid;
    logic                   axis_out_tready;
    logic [TDATA_WIDTH-1:0] axis_out_tdata;
    logic                   axis_out_tlast;
    logic [TID_WIDTH-1:0]   axis_out_tid;
    logic [TDEST_WIDTH-1:0] axis_out_tdest;

    modport slave (
        input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
        output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
               axis_out_tid, axis_out_tdest
    );

    modport master (
        output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
        input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
               axis_out_tid, axis_out_tdest
    );
endinterface

// File: rtl/noc_flit_sink_axis.sv
// Credit-based NoC link sink: buffers flits, packs SERIALIZATION_FACTOR flits per
// AXI-Stream beat, splits dest into tid/tdest and returns one credit per drained flit.
module noc_flit_sink_axis #(
    parameter int FLIT_BUFFER_DEPTH    = 8,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int TDATA_WIDTH          = 32,
    parameter int SERIALIZATION_FACTOR = 1,
    localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR,
    localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH
) (
    input  logic                     clk_noc,
    input  logic                     rst_n,
    noc_flit_sink_axis_if.slave      link,
    output logic                     overflow_err,
    output logic [15:0]              pkt_count
);
    localparam int AW = $clog2(FLIT_BUFFER_DEPTH);
    localparam int SF = SERIALIZATION_FACTOR;
    localparam int IW = (SF > 1) ? $clog2(SF) : 1;

    typedef struct packed {
        logic                  tail;
        logic [DEST_WIDTH-1:0] dest;
        logic [FLIT_WIDTH-1:0] data;
    } flit_t;

    flit_t mem [FLIT_BUFFER_DEPTH];

    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [TDATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic [TID_WIDTH-1:0]    tid_q, tid_d;
    logic [TDEST_WIDTH-1:0]  tdest_q, tdest_d;
    logic                    credit_q, credit_d;
    logic                    ovf_q, ovf_d;
    logic [15:0]             pkt_q, pkt_d;

    logic  full, empty, push, pop, hs;
    flit_t head;

    always_comb begin
        // Pointers carry an extra wrap bit so full and empty are distinguishable.
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        push  = link.send_in && !full;
        hs    = tvalid_q && link.axis_out_tready;
        pop   = !empty && (!tvalid_q || hs);
        head  = mem[rd_ptr_q[AW-1:0]];

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        idx_d    = idx_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        credit_d = pop;
        ovf_d    = ovf_q | (link.send_in & full);
        pkt_d    = pkt_q + 16'(hs && tlast_q);

        if (hs) begin
            tvalid_d = 1'b0;
        end

        if (pop) begin
            // Starting a new beat wipes every slice so a short beat has zero upper slices.
            if (idx_q == '0) begin
                tdata_d = '0;
            end
            tdata_d[idx_q*FLIT_WIDTH +: FLIT_WIDTH] = head.data;
            if (idx_q == IW'(SF - 1) || head.tail) begin
                tvalid_d = 1'b1;
                tlast_d  = head.tail;
                tid_d    = head.dest[DEST_WIDTH-1:TDEST_WIDTH];
                tdest_d  = head.dest[TDEST_WIDTH-1:0];
                idx_d    = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= {link.is_tail_in, link.dest_in, link.data_in};
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            idx_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tid_q    <= '0;
            tdest_q  <= '0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
            pkt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            idx_q    <= idx_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
            pkt_q    <= pkt_d;
        end
    end

    assign link.credit_out      = credit_q;
    assign link.axis_out_tvalid = tvalid_q;
    assign link.axis_out_tdata  = tdata_q;
    assign link.axis_out_tlast  = tlast_q;
    assign link.axis_out_tid    = tid_q;
    assign link.axis_out_tdest  = tdest_q;
    assign overflow_err         = ovf_q;
    assign pkt_count            = pkt_q;
endmodule

// File: tb/tb_noc_flit_sink_axis.sv
// Bench for noc_flit_sink_axis: one instance with 1 flit/beat, one with 4 byte flits/beat,
// driven by a credit-respecting sender and checked against a beat-level scoreboard.
module tb_noc_flit_sink_axis;
    logic clk_noc = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_noc = ~clk_noc;

    noc_flit_sink_axis_if #(.FLIT_WIDTH(32), .DEST_WIDTH(6), .TDATA_WIDTH(32)) if1 ();
    noc_flit_sink_axis_if #(.FLIT_WIDTH(8),  .DEST_WIDTH(6), .TDATA_WIDTH(32)) if4 ();
    logic        ovf1, ovf4;
    logic [15:0] pkt1, pkt4;

    noc_flit_sink_axis #(.SERIALIZATION_FACTOR(1)) u_dut1 (
        .clk_noc(clk_noc), .rst_n(rst_n), .link(if1.slave), .overflow_err(ovf1), .pkt_count(pkt1));
    noc_flit_sink_axis #(.SERIALIZATION_FACTOR(4)) u_dut4 (
        .clk_noc(clk_noc), .rst_n(rst_n), .link(if4.slave), .overflow_err(ovf4), .pkt_count(pkt4));

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  tid;
        logic [3:0]  tdest;
    } beat_t;

    beat_t exp0[$];
    beat_t exp1[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cred[2];
    int    credits_seen[2];
    int    beats_seen[2];
    int    exp_pkt[2];
    int    idx[2];
    logic [31:0] acc[2];
    logic [31:0] last_data[2];
    logic  pv[2];
    logic  phs[2];
    beat_t pbeat[2];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int u);
        return (u == 0) ? exp0.size() : exp1.size();
    endfunction

    // Scoreboard: pack flits into beats from the packetisation rules alone.
    task automatic model_flit(input int u, input logic [31:0] d, input logic [5:0] dest, input logic tail);
        int    fw = (u == 0) ? 32 : 8;
        int    sf = (u == 0) ? 1 : 4;
        beat_t b;
        logic [31:0] dm = (u == 0) ? d : {24'h0, d[7:0]};
        acc[u] = acc[u] | (dm << (idx[u] * fw));
        if (idx[u] == sf - 1 || tail) begin
            b.data = acc[u]; b.last = tail; b.tid = dest[5:4]; b.tdest = dest[3:0];
            if (u == 0) exp0.push_back(b); else exp1.push_back(b);
            acc[u] = '0;
            idx[u] = 0;
            if (tail) exp_pkt[u]++;
        end else begin
            idx[u]++;
        end
    endtask

    task automatic model_reset();
        exp0.delete();
        exp1.delete();
        for (int u = 0; u < 2; u++) begin
            cred[u] = 8; credits_seen[u] = 0; beats_seen[u] = 0;
            exp_pkt[u] = 0; idx[u] = 0; acc[u] = '0; last_data[u] = '0;
        end
    endtask

    task automatic set_in(input int u, input logic send, input logic [31:0] d,
                          input logic [5:0] dest, input logic tail, input logic rdy);
        if (u == 0) begin
            if1.send_in = send; if1.data_in = d; if1.dest_in = dest;
            if1.is_tail_in = tail; if1.axis_out_tready = rdy;
        end else begin
            if4.send_in = send; if4.data_in = d[7:0]; if4.dest_in = dest;
            if4.is_tail_in = tail; if4.axis_out_tready = rdy;
        end
    endtask

    task automatic drive(input int u, input logic send, input logic [31:0] d,
                         input logic [5:0] dest, input logic tail, input logic rdy);
        set_in(u, send, d, dest, tail, rdy);
        if (send) begin
            cred[u]--;
            model_flit(u, d, dest, tail);
        end
        @(posedge clk_noc);
        #1;
    endtask

    task automatic idle(input int u, input int n, input logic rdy);
        repeat (n) drive(u, 1'b0, 32'h0, 6'h0, 1'b0, rdy);
    endtask

    task automatic drain(input int u);
        int n = 0;
        while ((qsize(u) != 0 || (u == 0 ? if1.axis_out_tvalid : if4.axis_out_tvalid)) && n < 300) begin
            idle(u, 1, 1'b1);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
        idle(u, 4, 1'b1);
    endtask

    task automatic mon(input int u, input logic vld, input logic rdy, input logic [31:0] data,
                       input logic last, input logic [1:0] tid, input logic [3:0] tdest,
                       input logic credit);
        beat_t e;
        beat_t cur;
        if (!rst_n) begin
            pv[u] = 1'b0;
            phs[u] = 1'b0;
            return;
        end
        cur = {data, last, tid, tdest};
        if (credit) begin
            cred[u]++;
            credits_seen[u]++;
        end
        if (pv[u] && !phs[u]) begin
            chk("hold_tvalid", 64'(vld), 64'd1);
            chk("hold_beat", 64'(cur), 64'(pbeat[u]));
        end
        if (vld && rdy) begin
            beats_seen[u]++;
            last_data[u] = data;
            if (qsize(u) == 0) begin
                chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = (u == 0) ? exp0.pop_front() : exp1.pop_front();
                chk("tdata", 64'(data), 64'(e.data));
                chk("tlast", 64'(last), 64'(e.last));
                chk("tid",   64'(tid),  64'(e.tid));
                chk("tdest", 64'(tdest), 64'(e.tdest));
            end
        end
        pv[u]    = vld;
        phs[u]   = vld && rdy;
        pbeat[u] = cur;
    endtask

    always @(negedge clk_noc)
        mon(0, if1.axis_out_tvalid, if1.axis_out_tready, if1.axis_out_tdata, if1.axis_out_tlast,
            if1.axis_out_tid, if1.axis_out_tdest, if1.credit_out);
    always @(negedge clk_noc)
        mon(1, if4.axis_out_tvalid, if4.axis_out_tready, if4.axis_out_tdata, if4.axis_out_tlast,
            if4.axis_out_tid, if4.axis_out_tdest, if4.credit_out);

    task automatic rand_run(input int u, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            logic rdy  = ($urandom_range(0, 3) != 0);
            logic s    = (cred[u] > 0) && ($urandom_range(0, 1) == 1);
            logic tail = ($urandom_range(0, 2) == 0);
            drive(u, s, $urandom, 6'($urandom_range(0, 63)), tail, rdy);
        end
        drain(u);
        chk("rand_pkt_count", 64'(u == 0 ? pkt1 : pkt4), 64'(exp_pkt[u]));
        chk("rand_queue_empty", 64'(qsize(u)), 64'd0);
    endtask

    initial begin
        int n;
        model_reset();
        pv = '{default: 1'b0};
        phs = '{default: 1'b0};
        set_in(0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
        set_in(1, 1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
        repeat (3) @(posedge clk_noc);
        #1;
        chk("rst_tvalid", 64'(if1.axis_out_tvalid), 64'd0);
        chk("rst_credit", 64'(if1.credit_out | if4.credit_out), 64'd0);
        chk("rst_outs", 64'({ovf1, pkt1, if4.axis_out_tdata}), 64'd0);
        @(negedge clk_noc);
        rst_n = 1'b1;
        @(posedge clk_noc);
        #1;

        // Single-flit packet: latency and field split.
        drive(0, 1'b1, 32'hDEADBEEF, 6'h2A, 1'b1, 1'b1);
        set_in(0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
        @(negedge clk_noc);
        chk("lat_c1_tvalid", 64'(if1.axis_out_tvalid), 64'd0);
        chk("lat_c1_credit", 64'(if1.credit_out), 64'd0);
        @(negedge clk_noc);
        chk("lat_c2_tvalid", 64'(if1.axis_out_tvalid), 64'd1);
        chk("lat_c2_credit", 64'(if1.credit_out), 64'd1);
        chk("lat_beat", 64'({if1.axis_out_tdata, if1.axis_out_tlast, if1.axis_out_tid, if1.axis_out_tdest}),
            64'({32'hDEADBEEF, 1'b1, 2'd2, 4'hA}));
        @(negedge clk_noc);
        chk("lat_pkt_count", 64'(pkt1), 64'd1);
        drain(0);

        // Stalled consumer: 8 flits buffered, only the assembly register load returns a credit.
        credits_seen[0] = 0; beats_seen[0] = 0;
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 32'h100 + i, 6'(i), 1'b1, 1'b0);
        idle(0, 5, 1'b0);
        chk("stall_credits", 64'(credits_seen[0]), 64'd1);
        chk("stall_no_beats", 64'(beats_seen[0]), 64'd0);
        drain(0);
        chk("stall_total_credits", 64'(credits_seen[0]), 64'd8);
        chk("stall_beats", 64'(beats_seen[0]), 64'd8);

        // Overflow: exhaust credits, then push one flit without a credit.
        credits_seen[0] = 0; beats_seen[0] = 0;
        n = 0;
        while (cred[0] > 0 && n < 30) begin
            drive(0, 1'b1, 32'h200 + n, 6'h11, 1'b1, 1'b0);
            n++;
        end
        idle(0, 4, 1'b0);
        chk("ovf_accepted", 64'(n), 64'd9);
        chk("ovf_before", 64'(ovf1), 64'd0);
        set_in(0, 1'b1, 32'hBAD0BAD0, 6'h3F, 1'b1, 1'b0);
        @(posedge clk_noc);
        #1;
        set_in(0, 1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
        chk("ovf_set", 64'(ovf1), 64'd1);
        idle(0, 3, 1'b0);
        drain(0);
        chk("ovf_sticky", 64'(ovf1), 64'd1);
        chk("ovf_credits", 64'(credits_seen[0]), 64'd9);
        chk("ovf_beats", 64'(beats_seen[0]), 64'd9);
        chk("ovf_pkt_count", 64'(pkt1), 64'(exp_pkt[0]));

        rand_run(0, 400);

        // Reset with flits buffered: outputs clear at once, nothing old comes back.
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 32'h300 + i, 6'h05, 1'b1, 1'b0);
        idle(0, 2, 1'b0);
        @(negedge clk_noc);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs1", 64'({if1.axis_out_tvalid, if1.credit_out, if1.axis_out_tlast, if1.axis_out_tdata}), 64'd0);
        chk("mid_rst_ctrl", 64'({ovf1, pkt1, if1.axis_out_tid, if1.axis_out_tdest}), 64'd0);
        chk("mid_rst_outs4", 64'({if4.axis_out_tvalid, ovf4, pkt4}), 64'd0);
        model_reset();
        @(negedge clk_noc);
        #2;
        rst_n = 1'b1;
        idle(0, 12, 1'b1);
        chk("post_rst_credits", 64'(credits_seen[0]), 64'd0);
        chk("post_rst_beats", 64'(beats_seen[0]), 64'd0);

        // Four byte flits make one full beat.
        credits_seen[1] = 0; beats_seen[1] = 0;
        drive(1, 1'b1, 32'h11, 6'h17, 1'b0, 1'b1);
        drive(1, 1'b1, 32'h22, 6'h17, 1'b0, 1'b1);
        drive(1, 1'b1, 32'h33, 6'h17, 1'b0, 1'b1);
        drive(1, 1'b1, 32'h44, 6'h17, 1'b1, 1'b1);
        drain(1);
        chk("sf4_full_data", 64'(last_data[1]), 64'h44332211);
        chk("sf4_full_credits", 64'(credits_seen[1]), 64'd4);
        chk("sf4_full_beats", 64'(beats_seen[1]), 64'd1);

        // Early tail closes a short beat; the next packet restarts at slice 0.
        credits_seen[1] = 0; beats_seen[1] = 0;
        drive(1, 1'b1, 32'hAA, 6'h2C, 1'b0, 1'b1);
        drive(1, 1'b1, 32'hBB, 6'h2C, 1'b1, 1'b1);
        idle(1, 5, 1'b1);
        chk("sf4_short_data", 64'(last_data[1]), 64'h0000BBAA);
        drive(1, 1'b1, 32'h01, 6'h01, 1'b0, 1'b1);
        drive(1, 1'b1, 32'h02, 6'h01, 1'b0, 1'b1);
        drive(1, 1'b1, 32'h03, 6'h01, 1'b1, 1'b1);
        drain(1);
        chk("sf4_restart_data", 64'(last_data[1]), 64'h00030201);
        chk("sf4_short_credits", 64'(credits_seen[1]), 64'd5);
        chk("sf4_pkt_count", 64'(pkt4), 64'd3);

        rand_run(1, 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
